// File: rtl/led_fade_driver.sv
// PWM output stage for the LED sequencer: each channel's brightness ramps toward
// its on/off target in fixed steps, so pattern changes appear as crossfades.
module led_fade_driver #(
    parameter int NUM_LED  = 4,
    parameter int PWM_BITS = 8,
    parameter int STEP     = 32,
    parameter int STEP_DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_LED-1:0] led_in,
    output logic [NUM_LED-1:0] led_out,
    output logic               busy
);

    localparam int PCNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [PWM_BITS-1:0] MAX_V     = '1;
    localparam logic [PWM_BITS:0]   MAX_EXT   = {1'b0, MAX_V};
    localparam logic [PWM_BITS:0]   STEP_V    = (PWM_BITS+1)'(STEP);
    localparam logic [PCNT_W-1:0]   PCNT_LAST = PCNT_W'(STEP_DIV - 1);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [NUM_LED-1:0]  led_in_q;
    logic [NUM_LED-1:0]  led_out_q, led_out_d;
    logic                busy_q, busy_d;
    logic [PWM_BITS-1:0] level_q [NUM_LED];
    logic [PWM_BITS-1:0] level_d [NUM_LED];
    logic [PWM_BITS:0]   up_sum  [NUM_LED];
    logic [PWM_BITS:0]   dn_diff [NUM_LED];
    logic                step_tick;

    assign step_tick = (cnt_q == MAX_V) && (pcnt_q == PCNT_LAST);

    // Disabling the driver parks both counters at zero so re-enable restarts a full period.
    always_comb begin
        cnt_d  = '0;
        pcnt_d = '0;
        if (en) begin
            cnt_d  = cnt_q + PWM_BITS'(1);
            pcnt_d = pcnt_q;
            if (cnt_q == MAX_V) begin
                pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + PCNT_W'(1);
            end
        end
    end

    // NOTE: every signal gets a default before any branch, otherwise always_comb infers a latch.
    always_comb begin
        busy_d    = 1'b0;
        led_out_d = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            up_sum[i]  = {1'b0, level_q[i]} + STEP_V;
            dn_diff[i] = {1'b0, level_q[i]} - STEP_V;
            level_d[i] = level_q[i];
            if (!en) begin
                level_d[i] = '0;
            end else if (step_tick) begin
                // One extra bit lets both directions saturate instead of wrapping.
                if (led_in_q[i] && level_q[i] != MAX_V) begin
                    level_d[i] = (up_sum[i] > MAX_EXT) ? MAX_V : up_sum[i][PWM_BITS-1:0];
                end else if (!led_in_q[i] && level_q[i] != '0) begin
                    level_d[i] = dn_diff[i][PWM_BITS] ? '0 : dn_diff[i][PWM_BITS-1:0];
                end
            end
            if (level_d[i] != (led_in_q[i] ? MAX_V : '0)) begin
                busy_d = 1'b1;
            end
            // Full level bypasses the compare so the pin never blinks low at the wrap.
            led_out_d[i] = en && (level_q[i] == MAX_V || level_q[i] > cnt_q);
        end
    end

    // NOTE: state uses non-blocking assignments, and the level array is explicitly
    // cleared on reset because a mid-ramp reset must discard every channel's level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            pcnt_q    <= '0;
            led_in_q  <= '0;
            led_out_q <= '0;
            busy_q    <= 1'b0;
            for (int i = 0; i < NUM_LED; i++) begin
                level_q[i] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            pcnt_q    <= pcnt_d;
            led_in_q  <= led_in;
            led_out_q <= led_out_d;
            busy_q    <= busy_d;
            for (int i = 0; i < NUM_LED; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    assign led_out = led_out_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver: checks tick timing, per-period duty and busy
// across ramp-up, crossfade, saturation, enable drop and mid-ramp reset.
module tb_led_fade_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] led_in;
    logic [3:0] led_out;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    int prev_lvl[4];

    always #5 clk = ~clk;

    led_fade_driver #(
        .NUM_LED (4),
        .PWM_BITS(8),
        .STEP    (32),
        .STEP_DIV(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .led_in (led_in),
        .led_out(led_out),
        .busy   (busy)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic exp_busy(input int lv[4]);
        logic b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (lv[i] != (led_in[i] ? 255 : 0)) b = 1'b1;
        end
        return b;
    endfunction

    // Called half a period before a tick; ends half a period before the next one.
    task automatic tick_check(input string name, input int e0, input int e1,
                              input int e2, input int e3);
        int   e[4];
        int   hi[4];
        int   want;
        logic b;
        e  = '{e0, e1, e2, e3};
        hi = '{0, 0, 0, 0};
        step(255);
        b = exp_busy(prev_lvl);
        vectors++;
        if (busy !== b) begin
            miscompares++;
            $display("FAIL %s busy_before_tick: got %b expected %b", name, busy, b);
        end
        step(1);
        b = exp_busy(e);
        vectors++;
        if (busy !== b) begin
            miscompares++;
            $display("FAIL %s busy_after_tick: got %b expected %b", name, busy, b);
        end
        repeat (256) begin
            step(1);
            for (int i = 0; i < 4; i++) begin
                if (led_out[i] === 1'b1) hi[i]++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            want = (e[i] == 255) ? 256 : e[i];
            vectors++;
            if (hi[i] !== want) begin
                miscompares++;
                $display("FAIL %s duty ch%0d: got %0d high cycles expected %0d", name, i, hi[i], want);
            end
        end
        prev_lvl = e;
    endtask

    task automatic test_reset;
        en     = 1'b1;
        led_in = 4'b1111;
        rst    = 1'b1;
        step(3);
        vectors++;
        if (led_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset led_out: got %b expected 0000", led_out);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset busy: got %b expected 0", busy);
        end
        rst      = 1'b0;
        prev_lvl = '{0, 0, 0, 0};
        step(2);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset busy_cycle2: got %b expected 1", busy);
        end
        step(510);
        vectors++;
        if (led_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset pre_first_tick: got %b expected 0000", led_out);
        end
        step(1);
        vectors++;
        if (led_out !== 4'b1111) begin
            miscompares++;
            $display("FAIL reset post_first_tick: got %b expected 1111", led_out);
        end
    endtask

    task automatic test_ramp_up;
        led_in = 4'b0001;
        rst    = 1'b1;
        step(3);
        rst      = 1'b0;
        prev_lvl = '{0, 0, 0, 0};
        step(1);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ramp_up busy_cycle1: got %b expected 0", busy);
        end
        step(1);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ramp_up busy_cycle2: got %b expected 1", busy);
        end
        step(254);
        for (int k = 1; k <= 8; k++) begin
            tick_check("ramp_up", (k < 8) ? 32 * k : 255, 0, 0, 0);
        end
    endtask

    task automatic test_crossfade;
        led_in = 4'b0010;
        for (int k = 1; k <= 8; k++) begin
            tick_check("crossfade", (k < 8) ? 255 - 32 * k : 0, (k < 8) ? 32 * k : 255, 0, 0);
        end
    endtask

    task automatic test_saturation;
        led_in = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            tick_check("sat_up", (k < 8) ? 32 * k : 255, (k < 8) ? 255 - 32 * k : 0, 0, 0);
        end
        led_in = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            tick_check("sat_down", (k < 8) ? 255 - 32 * k : 0, 0, 0, 0);
        end
        tick_check("sat_floor", 0, 0, 0, 0);
        led_in = 4'b0001;
        for (int k = 1; k <= 3; k++) begin
            tick_check("reverse_up", 32 * k, 0, 0, 0);
        end
        led_in = 4'b0000;
        tick_check("reverse_down", 64, 0, 0, 0);
    endtask

    task automatic test_enable_drop;
        led_in = 4'b0001;
        tick_check("pre_drop", 96, 0, 0, 0);
        tick_check("pre_drop", 128, 0, 0, 0);
        step(10);
        vectors++;
        if (led_out !== 4'b0001) begin
            miscompares++;
            $display("FAIL en_drop before: got %b expected 0001", led_out);
        end
        en = 1'b0;
        step(1);
        vectors++;
        if (led_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL en_drop led_out: got %b expected 0000", led_out);
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL en_drop busy: got %b expected 1", busy);
        end
        step(299);
        vectors++;
        if (led_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL en_drop held: got %b expected 0000", led_out);
        end
        en       = 1'b1;
        prev_lvl = '{0, 0, 0, 0};
        step(256);
        tick_check("re_enable", 32, 0, 0, 0);
        tick_check("re_enable", 64, 0, 0, 0);
    endtask

    task automatic test_reset_mid_ramp;
        led_in = 4'b0100;
        for (int k = 1; k <= 5; k++) begin
            tick_check("pre_reset", (k == 1) ? 32 : 0, 0, 32 * k, 0);
        end
        step(10);
        vectors++;
        if (led_out !== 4'b0100) begin
            miscompares++;
            $display("FAIL mid_reset before: got %b expected 0100", led_out);
        end
        rst = 1'b1;
        step(1);
        vectors++;
        if (led_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset led_out: got %b expected 0000", led_out);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset busy: got %b expected 0", busy);
        end
        rst      = 1'b0;
        prev_lvl = '{0, 0, 0, 0};
        step(256);
        tick_check("post_reset", 0, 0, 32, 0);
        tick_check("post_reset", 0, 0, 64, 0);
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_crossfade();
        test_saturation();
        test_enable_drop();
        test_reset_mid_ramp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
